// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if: decode handshake, register-file read data, external ALU port
// and register-file write port of the ALU issue stage.
interface alu_issue_stage_if;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_op;
   logic [2:0] in_rs;
   logic [2:0] in_rt;
   logic [2:0] in_rd;
   logic [7:0] in_imm;
   logic       in_use_imm;

   logic [7:0] rs_data;
   logic [7:0] rt_data;

   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [2:0] alu_s;
   logic [7:0] alu_f;
   logic       alu_ovf;
   logic       alu_take_branch;

   logic       wb_en;
   logic [2:0] wb_addr;
   logic [7:0] wb_data;
   logic       flush;
   logic       ovf_sticky;

   // Issue-stage side
   modport slave (
      input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_use_imm,
      input  rs_data, rt_data,
      input  alu_f, alu_ovf, alu_take_branch,
      output in_ready, alu_a, alu_b, alu_s,
      output wb_en, wb_addr, wb_data, flush, ovf_sticky
   );

   // Decode / register-file / ALU side
   modport master (
      output in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_use_imm,
      output rs_data, rt_data,
      output alu_f, alu_ovf, alu_take_branch,
      input  in_ready, alu_a, alu_b, alu_s,
      input  wb_en, wb_addr, wb_data, flush, ovf_sticky
   );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: EX/WB slots feeding an external combinational 8-bit ALU.
// Macro ALU_ISSUE_FWD_EN selects operand forwarding; undefined, RAW hazards stall decode.
module alu_issue_stage #(
   parameter int unsigned REGS = 8
) (
   input logic              clk,
   input logic              rst,
   alu_issue_stage_if.slave bus
);
   localparam int unsigned AW = $clog2(REGS);

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_R1   = 3'b001,
      OP_R2   = 3'b010,
      OP_R3   = 3'b011,
      OP_R4   = 3'b100,
      OP_R5   = 3'b101,
      OP_CMP0 = 3'b110,
      OP_CMP1 = 3'b111
   } op_e;

   logic          ex_valid_q, ex_valid_d;
   op_e           ex_op_q, ex_op_d;
   logic [7:0]    ex_a_q, ex_a_d;
   logic [7:0]    ex_b_q, ex_b_d;
   logic [AW-1:0] ex_rd_q, ex_rd_d;
   logic          ex_wr_q, ex_wr_d;
   logic          wb_valid_q, wb_valid_d;
   logic [AW-1:0] wb_rd_q, wb_rd_d;
   logic [7:0]    wb_data_q, wb_data_d;
   logic          ovf_q, ovf_d;

   logic [AW-1:0] rs, rt, rd;
   logic          ex_prod, wb_prod;
   logic          ex_is_cmp;
   logic          flush;
   logic          accept;
   logic          ready;
   logic [7:0]    opa, opb_reg;

   assign rs = bus.in_rs[AW-1:0];
   assign rt = bus.in_rt[AW-1:0];
   assign rd = bus.in_rd[AW-1:0];

   // A slot is a producer only when it will actually write the register file.
   assign ex_prod   = ex_valid_q && ex_wr_q;
   assign wb_prod   = wb_valid_q;
   assign ex_is_cmp = (ex_op_q == OP_CMP0) || (ex_op_q == OP_CMP1);
   assign flush     = ex_valid_q && ex_is_cmp && bus.alu_take_branch;
   assign accept    = bus.in_valid && ready;

`ifdef ALU_ISSUE_FWD_EN
   function automatic logic [7:0] fwd(input logic [AW-1:0] r,
                                      input logic [7:0]    rf,
                                      input logic          ex_ok,
                                      input logic [AW-1:0] ex_rd,
                                      input logic [7:0]    ex_f,
                                      input logic          wb_ok,
                                      input logic [AW-1:0] wb_rd,
                                      input logic [7:0]    wb_d);
      if (r == '0)
         return rf;
      if (ex_ok && (ex_rd == r))
         return ex_f;
      if (wb_ok && (wb_rd == r))
         return wb_d;
      return rf;
   endfunction

   assign opa     = fwd(rs, bus.rs_data, ex_prod, ex_rd_q, bus.alu_f,
                        wb_prod, wb_rd_q, wb_data_q);
   assign opb_reg = fwd(rt, bus.rt_data, ex_prod, ex_rd_q, bus.alu_f,
                        wb_prod, wb_rd_q, wb_data_q);
   assign ready   = 1'b1;
`else
   function automatic logic hazard(input logic [AW-1:0] r,
                                   input logic          ex_ok,
                                   input logic [AW-1:0] ex_rd,
                                   input logic          wb_ok,
                                   input logic [AW-1:0] wb_rd);
      return (r != '0) && ((ex_ok && (ex_rd == r)) || (wb_ok && (wb_rd == r)));
   endfunction

   assign opa     = bus.rs_data;
   assign opb_reg = bus.rt_data;
   // rt only matters when the immediate is not selected.
   assign ready   = !(bus.in_valid &&
                      (hazard(rs, ex_prod, ex_rd_q, wb_prod, wb_rd_q) ||
                       (!bus.in_use_imm && hazard(rt, ex_prod, ex_rd_q, wb_prod, wb_rd_q))));
`endif

   always_comb begin
      ex_valid_d = accept && !flush;
      ex_op_d    = ex_op_q;
      ex_a_d     = ex_a_q;
      ex_b_d     = ex_b_q;
      ex_rd_d    = ex_rd_q;
      ex_wr_d    = ex_wr_q;
      if (accept) begin
         ex_op_d = op_e'(bus.in_op);
         ex_a_d  = opa;
         ex_b_d  = bus.in_use_imm ? bus.in_imm : opb_reg;
         ex_rd_d = rd;
         ex_wr_d = (bus.in_op[2:1] != 2'b11) && (rd != '0);
      end

      wb_valid_d = 1'b0;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
      if (ex_valid_q) begin
         wb_valid_d = ex_wr_q;
         wb_rd_d    = ex_rd_q;
         wb_data_d  = bus.alu_f;
      end

      ovf_d = ovf_q || (ex_valid_q && (ex_op_q == OP_ADD) && bus.alu_ovf);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid_q <= 1'b0;
         ex_op_q    <= OP_ADD;
         ex_a_q     <= '0;
         ex_b_q     <= '0;
         ex_rd_q    <= '0;
         ex_wr_q    <= 1'b0;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         ovf_q      <= 1'b0;
      end else begin
         ex_valid_q <= ex_valid_d;
         ex_op_q    <= ex_op_d;
         ex_a_q     <= ex_a_d;
         ex_b_q     <= ex_b_d;
         ex_rd_q    <= ex_rd_d;
         ex_wr_q    <= ex_wr_d;
         wb_valid_q <= wb_valid_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         ovf_q      <= ovf_d;
      end
   end

   assign bus.in_ready   = ready;
   assign bus.alu_a      = ex_valid_q ? ex_a_q : '0;
   assign bus.alu_b      = ex_valid_q ? ex_b_q : '0;
   assign bus.alu_s      = ex_valid_q ? 3'(ex_op_q) : 3'b000;
   assign bus.wb_en      = wb_valid_q;
   assign bus.wb_addr    = wb_rd_q;
   assign bus.wb_data    = wb_data_q;
   assign bus.flush      = flush;
   assign bus.ovf_sticky = ovf_q;
endmodule
